// File: rtl/traffic_pkg.sv
// Shared lamp codes and FSM state encoding for the traffic phase controller.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_MG   = 3'd1,
    S_MY   = 3'd2,
    S_LG   = 3'd3,
    S_LY   = 3'd4,
    S_PED  = 3'd5,
    S_AR   = 3'd6
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable phase down-counter; counting and loading both gated by i_en (the hold freeze).
module phase_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_count <= i_load_val;
      end else if (r_count != '0) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic controller: per-road main/left phases, round-robin, pedestrian walk
// served at cycle end. Define TRAFFIC_ALLRED_EN to insert all-red clearance phases.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_ROADS = 4,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned GREEN_T   = 15,
  parameter int unsigned LEFT_T    = 8,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned PED_T     = 10,
  parameter int unsigned ALLRED_T  = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         hold,
  input  logic                         ped_req,
  output logic                         ped_ack,
  output logic [$clog2(NUM_ROADS)-1:0] road_idx,
  output logic [CNT_W-1:0]             count,
  output logic [3*NUM_ROADS-1:0]       sig_main,
  output logic [3*NUM_ROADS-1:0]       sig_left,
  output logic                         sig_ped
);

  localparam int unsigned IDX_W = $clog2(NUM_ROADS);
  localparam logic [IDX_W-1:0] LAST_ROAD = IDX_W'(NUM_ROADS - 1);

  state_e                 r_state, w_state_d;
  logic [IDX_W-1:0]       r_road, w_road_d, w_road_inc;
  logic                   r_ped_pend, w_ped_pend_d;
  logic                   r_ped_ack, r_sig_ped;
  logic [3*NUM_ROADS-1:0] r_sig_main, r_sig_left, w_main_d, w_left_d;
  logic [CNT_W-1:0]       w_count, w_load_val;
  logic                   w_zero, w_adv, w_last, w_ped_any;

  assign w_adv      = !hold && w_zero;
  assign w_last     = (r_road == LAST_ROAD);
  assign w_road_inc = w_last ? '0 : r_road + IDX_W'(1);
  // A request arriving in the deciding cycle itself still wins this cycle's walk.
  assign w_ped_any  = r_ped_pend || ped_req;

`ifdef TRAFFIC_ALLRED_EN
  // Remembers whether the current all-red follows a walk (go to road 0) or a left yellow.
  logic r_ar_ped, w_ar_ped_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ar_ped <= 1'b0;
    else          r_ar_ped <= w_ar_ped_d;
  end
`endif

  always_comb begin
    w_state_d = r_state;
    w_road_d  = r_road;
`ifdef TRAFFIC_ALLRED_EN
    w_ar_ped_d = r_ar_ped;
`endif
    if (w_adv) begin
      unique case (r_state)
        S_INIT: begin
          w_state_d = S_MG;
          w_road_d  = '0;
        end
        S_MG: w_state_d = S_MY;
        S_MY: w_state_d = S_LG;
        S_LG: w_state_d = S_LY;
        S_LY: begin
`ifdef TRAFFIC_ALLRED_EN
          w_state_d  = S_AR;
          w_ar_ped_d = 1'b0;
`else
          w_state_d = (w_last && w_ped_any) ? S_PED : S_MG;
          w_road_d  = w_road_inc;
`endif
        end
        S_PED: begin
`ifdef TRAFFIC_ALLRED_EN
          w_state_d  = S_AR;
          w_ar_ped_d = 1'b1;
`else
          w_state_d = S_MG;
`endif
          w_road_d = '0;
        end
`ifdef TRAFFIC_ALLRED_EN
        S_AR: begin
          if (r_ar_ped) begin
            w_state_d = S_MG;
            w_road_d  = '0;
          end else begin
            w_state_d = (w_last && w_ped_any) ? S_PED : S_MG;
            w_road_d  = w_road_inc;
          end
        end
`endif
        default: begin
          w_state_d = S_INIT;
          w_road_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_load_val = '0;
    unique case (w_state_d)
      S_MG:    w_load_val = CNT_W'(GREEN_T - 1);
      S_MY:    w_load_val = CNT_W'(YELLOW_T - 1);
      S_LG:    w_load_val = CNT_W'(LEFT_T - 1);
      S_LY:    w_load_val = CNT_W'(YELLOW_T - 1);
      S_PED:   w_load_val = CNT_W'(PED_T - 1);
      S_AR:    w_load_val = CNT_W'(ALLRED_T - 1);
      default: w_load_val = '0;
    endcase
  end

  always_comb begin
    w_main_d = {NUM_ROADS{LAMP_RED}};
    w_left_d = {NUM_ROADS{LAMP_RED}};
    for (int k = 0; k < NUM_ROADS; k++) begin
      if (IDX_W'(k) == w_road_d) begin
        unique case (w_state_d)
          S_MG:    w_main_d[3*k +: 3] = LAMP_GRN;
          S_MY:    w_main_d[3*k +: 3] = LAMP_YEL;
          S_LG:    w_left_d[3*k +: 3] = LAMP_GRN;
          S_LY:    w_left_d[3*k +: 3] = LAMP_YEL;
          default: ;
        endcase
      end
    end
  end

  // Entering the walk consumes every request seen up to and including the deciding cycle.
  assign w_ped_pend_d = (w_adv && w_state_d == S_PED) ? 1'b0 : w_ped_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_INIT;
      r_road     <= '0;
      r_ped_pend <= 1'b0;
      r_ped_ack  <= 1'b0;
      r_sig_ped  <= 1'b0;
      r_sig_main <= {NUM_ROADS{LAMP_RED}};
      r_sig_left <= {NUM_ROADS{LAMP_RED}};
    end else begin
      r_state    <= w_state_d;
      r_road     <= w_road_d;
      r_ped_pend <= w_ped_pend_d;
      r_ped_ack  <= w_adv && (w_state_d == S_PED);
      r_sig_ped  <= (w_state_d == S_PED);
      r_sig_main <= w_main_d;
      r_sig_left <= w_left_d;
    end
  end

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (!hold),
    .i_load    (w_adv),
    .i_load_val(w_load_val),
    .o_count   (w_count),
    .o_zero    (w_zero)
  );

  assign road_idx = r_road;
  assign count    = w_count;
  assign sig_main = r_sig_main;
  assign sig_left = r_sig_left;
  assign sig_ped  = r_sig_ped;
  assign ped_ack  = r_ped_ack;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: vector table, directed corner cases, and a
// randomized run against a phase-schedule queue model.
module tb_traffic_phase_ctrl;

  localparam int NR = 4;
  localparam int GT = 4;
  localparam int LT = 3;
  localparam int YT = 2;
  localparam int PT = 3;
  localparam int AT = 2;
`ifdef TRAFFIC_ALLRED_EN
  localparam int CYC = 52;
`else
  localparam int CYC = 44;
`endif

  localparam logic [2:0] RD = 3'b100;
  localparam logic [2:0] YL = 3'b010;
  localparam logic [2:0] GN = 3'b001;
  localparam logic [11:0] ALLR = {RD, RD, RD, RD};

  localparam int K_INIT = 0, K_MG = 1, K_MY = 2, K_LG = 3, K_LY = 4, K_PED = 5, K_AR = 6;

  logic        clk = 1'b0;
  logic        reset_n, hold, ped_req;
  logic        ped_ack, sig_ped;
  logic [1:0]  road_idx;
  logic [4:0]  count;
  logic [11:0] sig_main, sig_left;

  int vectors = 0;
  int miscompares = 0;

  traffic_phase_ctrl #(
    .NUM_ROADS(NR), .CNT_W(5), .GREEN_T(GT), .LEFT_T(LT), .YELLOW_T(YT), .PED_T(PT),
    .ALLRED_T(AT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (hold),
    .ped_req (ped_req),
    .ped_ack (ped_ack),
    .road_idx(road_idx),
    .count   (count),
    .sig_main(sig_main),
    .sig_left(sig_left),
    .sig_ped (sig_ped)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of upcoming phases, refilled with a whole round at cycle end.
  typedef struct {int kind; int road; int len;} ph_t;
  ph_t q[$];
  ph_t cur;
  int  el;
  bit  m_pend, m_ack;

  function automatic void push_round();
    for (int r = 0; r < NR; r++) begin
      q.push_back('{K_MG, r, GT});
      q.push_back('{K_MY, r, YT});
      q.push_back('{K_LG, r, LT});
      q.push_back('{K_LY, r, YT});
`ifdef TRAFFIC_ALLRED_EN
      q.push_back('{K_AR, r, AT});
`endif
    end
  endfunction

  function automatic void m_reset();
    q.delete();
    cur    = '{K_INIT, 0, 1};
    el     = 0;
    m_pend = 1'b0;
    m_ack  = 1'b0;
  endfunction

  function automatic void m_step(bit h, bit r);
    m_ack = 1'b0;
    if (h) begin
      m_pend |= r;
    end else if (el == cur.len - 1) begin
      if (q.size() == 0) begin
        if (cur.kind != K_INIT && (m_pend || r)) begin
          q.push_back('{K_PED, 0, PT});
`ifdef TRAFFIC_ALLRED_EN
          q.push_back('{K_AR, 0, AT});
`endif
        end
        push_round();
      end
      cur = q.pop_front();
      el  = 0;
      if (cur.kind == K_PED) begin
        m_ack  = 1'b1;
        m_pend = 1'b0;
      end else begin
        m_pend |= r;
      end
    end else begin
      el++;
      m_pend |= r;
    end
  endfunction

  function automatic logic [11:0] exp_lamps(int kind, int road, bit left);
    logic [11:0] v;
    v = ALLR;
    if (!left && kind == K_MG) v[3*road +: 3] = GN;
    if (!left && kind == K_MY) v[3*road +: 3] = YL;
    if (left && kind == K_LG)  v[3*road +: 3] = GN;
    if (left && kind == K_LY)  v[3*road +: 3] = YL;
    return v;
  endfunction

  function automatic bit lamps_legal();
    int nonred;
    logic [2:0] m, l;
    nonred = 0;
    for (int k = 0; k < NR; k++) begin
      m = sig_main[3*k +: 3];
      l = sig_left[3*k +: 3];
      if (!(m inside {RD, YL, GN}) || !(l inside {RD, YL, GN})) return 1'b0;
      if (m != RD && l != RD) return 1'b0;
      if (m != RD || l != RD) nonred++;
    end
    return nonred <= 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("road_idx", 32'(road_idx), 32'(cur.road));
    chk("count", 32'(count), 32'(cur.len - 1 - el));
    chk("sig_main", 32'(sig_main), 32'(exp_lamps(cur.kind, cur.road, 1'b0)));
    chk("sig_left", 32'(sig_left), 32'(exp_lamps(cur.kind, cur.road, 1'b1)));
    chk("sig_ped", 32'(sig_ped), 32'(cur.kind == K_PED));
    chk("ped_ack", 32'(ped_ack), 32'(m_ack));
    chk("lamps_legal", 32'(lamps_legal()), 32'd1);
  endtask

  task automatic tick(input logic h, input logic r);
    hold    = h;
    ped_req = r;
    @(posedge clk);
    #1;
    m_step(h, r);
    compare_model();
  endtask

  // Asserts reset mid-cycle, checks outputs asynchronously, releases on the next falling edge.
  task automatic do_reset();
    #2;
    hold    = 1'b0;
    ped_req = 1'b0;
    reset_n = 1'b0;
    #1;
    m_reset();
    compare_model();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_main", 32'(sig_main), 32'(ALLR));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        hold;
    logic        req;
    logic [1:0]  road;
    logic [4:0]  cnt;
    logic [11:0] main;
    logic [11:0] left;
    logic        ped;
    logic        ack;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before t=200000");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 2'd0, 5'd3, {RD, RD, RD, GN}, ALLR, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 5'd2, {RD, RD, RD, GN}, ALLR, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 5'd1, {RD, RD, RD, GN}, ALLR, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 5'd0, {RD, RD, RD, GN}, ALLR, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 5'd1, {RD, RD, RD, YL}, ALLR, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 5'd0, {RD, RD, RD, YL}, ALLR, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 5'd2, ALLR, {RD, RD, RD, GN}, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 5'd1, ALLR, {RD, RD, RD, GN}, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 5'd0, ALLR, {RD, RD, RD, GN}, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 5'd1, ALLR, {RD, RD, RD, YL}, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 5'd0, ALLR, {RD, RD, RD, YL}, 1'b0, 1'b0};
`ifdef TRAFFIC_ALLRED_EN
    tbl[11] = '{1'b0, 1'b0, 2'd0, 5'd1, ALLR, ALLR, 1'b0, 1'b0};
`else
    tbl[11] = '{1'b0, 1'b0, 2'd1, 5'd3, {RD, RD, GN, RD}, ALLR, 1'b0, 1'b0};
`endif

    reset_n = 1'b0;
    hold    = 1'b0;
    ped_req = 1'b0;
    m_reset();
    #12;
    compare_model();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].hold, tbl[i].req);
      chk("tbl_road", 32'(road_idx), 32'(tbl[i].road));
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_main", 32'(sig_main), 32'(tbl[i].main));
      chk("tbl_left", 32'(sig_left), 32'(tbl[i].left));
      chk("tbl_ped", 32'(sig_ped), 32'(tbl[i].ped));
      chk("tbl_ack", 32'(ped_ack), 32'(tbl[i].ack));
    end

    // Back at the start of the next round after exactly one cycle length.
    repeat (CYC - 11) tick(1'b0, 1'b0);
    chk("wrap_road", 32'(road_idx), 32'd0);
    chk("wrap_count", 32'(count), 32'd3);
    chk("wrap_main", 32'(sig_main), 32'({RD, RD, RD, GN}));

`ifndef TRAFFIC_ALLRED_EN
    // Single-cycle request during road 1 main green.
    repeat (11) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (31) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("walk_ack", 32'(ped_ack), 32'd1);
    chk("walk_ped", 32'(sig_ped), 32'd1);
    chk("walk_count", 32'(count), 32'd2);
    chk("walk_main", 32'(sig_main), 32'(ALLR));
    tick(1'b0, 1'b0);
    chk("walk_ack_pulse", 32'(ped_ack), 32'd0);
    tick(1'b0, 1'b0);
    chk("walk_last", 32'(sig_ped), 32'd1);
    tick(1'b0, 1'b0);
    chk("post_walk_ped", 32'(sig_ped), 32'd0);
    chk("post_walk_main", 32'(sig_main), 32'({RD, RD, RD, GN}));

    // Hold during road 2 left green with count 1.
    repeat (29) tick(1'b0, 1'b0);
    chk("hold_pre_count", 32'(count), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      chk("hold_count", 32'(count), 32'd1);
      chk("hold_left", 32'(sig_left), 32'({RD, GN, RD, RD}));
    end
    tick(1'b0, 1'b0);
    chk("hold_resume", 32'(count), 32'd0);
    repeat (13) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("no_walk_ack", 32'(ped_ack), 32'd0);
    chk("no_walk_main", 32'(sig_main), 32'({RD, RD, RD, GN}));

    // Request held through the walk re-arms a second walk.
    repeat (43) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("walk2_ack", 32'(ped_ack), 32'd1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    repeat (43) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("rearm_ack", 32'(ped_ack), 32'd1);
    chk("rearm_ped", 32'(sig_ped), 32'd1);
    repeat (3) tick(1'b0, 1'b0);

    // Reset mid road 1 main yellow, with a request pending that reset must discard.
    tick(1'b0, 1'b1);
    repeat (14) tick(1'b0, 1'b0);
    chk("pre_rst_main", 32'(sig_main), 32'({RD, RD, YL, RD}));
    do_reset();
    chk("rst_road", 32'(road_idx), 32'd0);
    chk("rst_ped", 32'(sig_ped), 32'd0);
    tick(1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd3);
    repeat (CYC) tick(1'b0, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
